// File: rtl/video_pkg.sv
// Shared video definitions: bar colours, RGB888 pixel type and standard raster timings.
package video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [2:0] {
    BAR_WHITE, BAR_YELLOW, BAR_CYAN, BAR_GREEN,
    BAR_MAGENTA, BAR_RED, BAR_BLUE, BAR_BLACK
  } bar_t;

  localparam rgb_t COLOR_WHITE   = 24'hFFFFFF;
  localparam rgb_t COLOR_YELLOW  = 24'hFFFF00;
  localparam rgb_t COLOR_CYAN    = 24'h00FFFF;
  localparam rgb_t COLOR_GREEN   = 24'h00FF00;
  localparam rgb_t COLOR_MAGENTA = 24'hFF00FF;
  localparam rgb_t COLOR_RED     = 24'hFF0000;
  localparam rgb_t COLOR_BLUE    = 24'h0000FF;
  localparam rgb_t COLOR_BLACK   = 24'h000000;

  localparam logic [15:0] H_ACTIVE_720P  = 16'd1280;
  localparam logic [15:0] H_FP_720P      = 16'd110;
  localparam logic [15:0] H_SYNC_720P    = 16'd40;
  localparam logic [15:0] H_BP_720P      = 16'd220;
  localparam logic [15:0] V_ACTIVE_720P  = 16'd720;
  localparam logic [15:0] V_FP_720P      = 16'd5;
  localparam logic [15:0] V_SYNC_720P    = 16'd5;
  localparam logic [15:0] V_BP_720P      = 16'd20;

  localparam logic [15:0] H_ACTIVE_1080P = 16'd1920;
  localparam logic [15:0] H_FP_1080P     = 16'd88;
  localparam logic [15:0] H_SYNC_1080P   = 16'd44;
  localparam logic [15:0] H_BP_1080P     = 16'd148;
  localparam logic [15:0] V_ACTIVE_1080P = 16'd1080;
  localparam logic [15:0] V_FP_1080P     = 16'd4;
  localparam logic [15:0] V_SYNC_1080P   = 16'd5;
  localparam logic [15:0] V_BP_1080P     = 16'd36;

  function automatic rgb_t bar_color(input bar_t idx);
    rgb_t c;
    case (idx)
      BAR_WHITE:   c = COLOR_WHITE;
      BAR_YELLOW:  c = COLOR_YELLOW;
      BAR_CYAN:    c = COLOR_CYAN;
      BAR_GREEN:   c = COLOR_GREEN;
      BAR_MAGENTA: c = COLOR_MAGENTA;
      BAR_RED:     c = COLOR_RED;
      BAR_BLUE:    c = COLOR_BLUE;
      default:     c = COLOR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Free-running h/v raster counters with registered hs/vs/de decode.
module video_timing_cnt
  import video_pkg::*;
#(
  parameter logic [15:0] H_ACTIVE = H_ACTIVE_720P,
  parameter logic [15:0] H_FP     = H_FP_720P,
  parameter logic [15:0] H_SYNC   = H_SYNC_720P,
  parameter logic [15:0] H_BP     = H_BP_720P,
  parameter logic [15:0] V_ACTIVE = V_ACTIVE_720P,
  parameter logic [15:0] V_FP     = V_FP_720P,
  parameter logic [15:0] V_SYNC   = V_SYNC_720P,
  parameter logic [15:0] V_BP     = V_BP_720P,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  output logic hs,
  output logic vs,
  output logic de,
  output logic h_last,
  output logic active
);

  localparam logic [15:0] H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [15:0] V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [15:0] H_SYNC_START = H_ACTIVE + H_FP;
  localparam logic [15:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [15:0] V_SYNC_START = V_ACTIVE + V_FP;
  localparam logic [15:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic [15:0] h_cnt;
  logic [15:0] v_cnt;
  logic        v_last;
  logic        hs_win;
  logic        vs_win;

  always_comb begin
    h_last = (h_cnt == H_TOTAL - 16'd1);
    v_last = (v_cnt == V_TOTAL - 16'd1);
    hs_win = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
    vs_win = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
    active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 16'd1;
    end else begin
      h_cnt <= h_cnt + 16'd1;
    end
  end

  // Outputs reflect the counter state before this edge's increment: one clock latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs <= ~HS_POL;
      vs <= ~VS_POL;
      de <= 1'b0;
    end else begin
      hs <= hs_win ? HS_POL : ~HS_POL;
      vs <= vs_win ? VS_POL : ~VS_POL;
      de <= active;
    end
  end

endmodule

// File: rtl/video_color_bar.sv
// Video timing generator with an 8-bar colour test pattern on the active area.
module video_color_bar
  import video_pkg::*;
#(
  parameter logic [15:0] H_ACTIVE = H_ACTIVE_720P,
  parameter logic [15:0] H_FP     = H_FP_720P,
  parameter logic [15:0] H_SYNC   = H_SYNC_720P,
  parameter logic [15:0] H_BP     = H_BP_720P,
  parameter logic [15:0] V_ACTIVE = V_ACTIVE_720P,
  parameter logic [15:0] V_FP     = V_FP_720P,
  parameter logic [15:0] V_SYNC   = V_SYNC_720P,
  parameter logic [15:0] V_BP     = V_BP_720P,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hs,
  output logic       vs,
  output logic       de,
  output logic [7:0] rgb_r,
  output logic [7:0] rgb_g,
  output logic [7:0] rgb_b
);

  localparam logic [15:0] BAR_W = H_ACTIVE >> 3;

  logic        h_last;
  logic        active;
  logic [15:0] pix_cnt;
  bar_t        bar_idx;
  rgb_t        rgb_q;

  video_timing_cnt #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk    (clk),
    .rst_n  (rst_n),
    .hs     (hs),
    .vs     (vs),
    .de     (de),
    .h_last (h_last),
    .active (active)
  );

  // bar_idx tracks h_cnt/BAR_W in step with the counters; it saturates at black,
  // which also covers leftover pixels past 8*BAR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
      bar_idx <= BAR_WHITE;
    end else if (h_last) begin
      pix_cnt <= '0;
      bar_idx <= BAR_WHITE;
    end else if (bar_idx != BAR_BLACK) begin
      if (pix_cnt == BAR_W - 16'd1) begin
        pix_cnt <= '0;
        bar_idx <= bar_t'(bar_idx + 3'd1);
      end else begin
        pix_cnt <= pix_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= active ? bar_color(bar_idx) : '0;
    end
  end

  assign rgb_r = rgb_q.r;
  assign rgb_g = rgb_q.g;
  assign rgb_b = rgb_q.b;

endmodule

// File: tb/tb_video_color_bar.sv
// Scoreboard bench: stimulus queues expected pixel states per cycle, a monitor compares each clock.
module tb_video_color_bar;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic hs_a, vs_a, de_a, hs_b, vs_b, de_b, hs_c, vs_c, de_c;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;

  // 720p defaults
  video_color_bar dut_a (
    .clk(clk), .rst_n(rst_a), .hs(hs_a), .vs(vs_a), .de(de_a),
    .rgb_r(r_a), .rgb_g(g_a), .rgb_b(b_a)
  );

  // Small raster: H_TOTAL=47, V_TOTAL=13, BAR_W=4 with 3 leftover pixels
  video_color_bar #(
    .H_ACTIVE(16'd35), .H_FP(16'd3), .H_SYNC(16'd4), .H_BP(16'd5),
    .V_ACTIVE(16'd6),  .V_FP(16'd2), .V_SYNC(16'd3), .V_BP(16'd2)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .hs(hs_b), .vs(vs_b), .de(de_b),
    .rgb_r(r_b), .rgb_g(g_b), .rgb_b(b_b)
  );

  video_color_bar #(
    .H_ACTIVE(16'd35), .H_FP(16'd3), .H_SYNC(16'd4), .H_BP(16'd5),
    .V_ACTIVE(16'd6),  .V_FP(16'd2), .V_SYNC(16'd3), .V_BP(16'd2),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_c (
    .clk(clk), .rst_n(rst_c), .hs(hs_c), .vs(vs_c), .de(de_c),
    .rgb_r(r_c), .rgb_g(g_c), .rgb_b(b_c)
  );

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         inst;
    longint     cyc;
    logic [2:0] hvd;
    logic [23:0] rgb;
  } exp_t;

  exp_t   q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  longint base    = 0;

  task automatic push_at(input string name, input int inst, input longint c,
                         input logic [2:0] hvd, input logic [23:0] rgb);
    exp_t e;
    e.name = name; e.inst = inst; e.cyc = c; e.hvd = hvd; e.rgb = rgb;
    q.push_back(e);
  endtask

  // Pixel p after reset release appears at cycle base+1+p.
  task automatic px(input string name, input int inst, input longint p,
                    input logic [2:0] hvd, input logic [23:0] rgb);
    push_at(name, inst, base + 1 + p, hvd, rgb);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && q.size() > 0; i++) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    logic [26:0] act;
    forever begin
      @(negedge clk);
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_tests++;
        case (e.inst)
          0:       act = {hs_a, vs_a, de_a, r_a, g_a, b_a};
          1:       act = {hs_b, vs_b, de_b, r_b, g_b, b_b};
          default: act = {hs_c, vs_c, de_c, r_c, g_c, b_c};
        endcase
        if (e.cyc != cyc) begin
          n_fail++;
          $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
        end else if (act !== {e.hvd, e.rgb}) begin
          n_fail++;
          $display("FAIL %s: cyc=%0d got hs/vs/de=%b rgb=%06h, expected hs/vs/de=%b rgb=%06h",
                   e.name, cyc, act[26:24], act[23:0], e.hvd, e.rgb);
        end
      end
    end
  end

  initial begin : stimulus
    longint c0;
    exp_t   e;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (3) @(negedge clk);

    // 720p: horizontal timing and bar colours on lines 0/1
    push_at("a_reset", 0, cyc, 3'b000, 24'h000000);
    @(negedge clk);
    rst_a = 1'b1; base = cyc;
    px("a_x0",      0, 0,    3'b001, 24'hFFFFFF);
    px("a_x159",    0, 159,  3'b001, 24'hFFFFFF);
    px("a_x160",    0, 160,  3'b001, 24'hFFFF00);
    px("a_x320",    0, 320,  3'b001, 24'h00FFFF);
    px("a_x480",    0, 480,  3'b001, 24'h00FF00);
    px("a_x640",    0, 640,  3'b001, 24'hFF00FF);
    px("a_x800",    0, 800,  3'b001, 24'hFF0000);
    px("a_x960",    0, 960,  3'b001, 24'h0000FF);
    px("a_x1119",   0, 1119, 3'b001, 24'h0000FF);
    px("a_x1120",   0, 1120, 3'b001, 24'h000000);
    px("a_x1279",   0, 1279, 3'b001, 24'h000000);
    px("a_x1280",   0, 1280, 3'b000, 24'h000000);
    px("a_hs_pre",  0, 1389, 3'b000, 24'h000000);
    px("a_hs_rise", 0, 1390, 3'b100, 24'h000000);
    px("a_hs_last", 0, 1429, 3'b100, 24'h000000);
    px("a_hs_fall", 0, 1430, 3'b000, 24'h000000);
    px("a_x1649",   0, 1649, 3'b000, 24'h000000);
    px("a_l1_x0",   0, 1650, 3'b001, 24'hFFFFFF);
    px("a_l1_x1279",0, 2929, 3'b001, 24'h000000);
    px("a_l1_x1280",0, 2930, 3'b000, 24'h000000);
    px("a_l2_x0",   0, 3300, 3'b001, 24'hFFFFFF);
    drain(4000);

    // Small raster, active-high sync: leftover pixels, vertical timing, frame wrap
    push_at("b_reset", 1, cyc, 3'b000, 24'h000000);
    @(negedge clk);
    rst_b = 1'b1; base = cyc;
    px("b_x0",       1, 0,    3'b001, 24'hFFFFFF);
    px("b_x3",       1, 3,    3'b001, 24'hFFFFFF);
    px("b_x4",       1, 4,    3'b001, 24'hFFFF00);
    px("b_x27",      1, 27,   3'b001, 24'h0000FF);
    px("b_x28",      1, 28,   3'b001, 24'h000000);
    px("b_x31",      1, 31,   3'b001, 24'h000000);
    px("b_left32",   1, 32,   3'b001, 24'h000000);
    px("b_left34",   1, 34,   3'b001, 24'h000000);
    px("b_x35",      1, 35,   3'b000, 24'h000000);
    px("b_hs_pre",   1, 37,   3'b000, 24'h000000);
    px("b_hs_rise",  1, 38,   3'b100, 24'h000000);
    px("b_hs_last",  1, 41,   3'b100, 24'h000000);
    px("b_hs_fall",  1, 42,   3'b000, 24'h000000);
    px("b_x46",      1, 46,   3'b000, 24'h000000);
    px("b_l1_x0",    1, 47,   3'b001, 24'hFFFFFF);
    px("b_l5_x0",    1, 235,  3'b001, 24'hFFFFFF);
    px("b_l6_x0",    1, 282,  3'b000, 24'h000000);
    px("b_vs_pre",   1, 375,  3'b000, 24'h000000);
    px("b_vs_rise",  1, 376,  3'b010, 24'h000000);
    px("b_vs_hs",    1, 414,  3'b110, 24'h000000);
    px("b_vs_last",  1, 516,  3'b010, 24'h000000);
    px("b_vs_fall",  1, 517,  3'b000, 24'h000000);
    px("b_frm_end",  1, 610,  3'b000, 24'h000000);
    px("b_frm2_x0",  1, 611,  3'b001, 24'hFFFFFF);
    px("b_frm2_vs",  1, 987,  3'b010, 24'h000000);
    px("b_f2l3_x9",  1, 1372, 3'b001, 24'h00FFFF);
    for (int i = 0; i < 3000 && cyc < base + 1 + 1373; i++) @(negedge clk);

    // Mid-line reset: outputs drop at once and the frame restarts at (0,0)
    c0 = cyc;
    push_at("b_rst_async", 1, c0,     3'b000, 24'h000000);
    push_at("b_rst_hold",  1, c0 + 4, 3'b000, 24'h000000);
    push_at("b_rst_end",   1, c0 + 9, 3'b000, 24'h000000);
    rst_b = 1'b0;
    repeat (10) @(negedge clk);
    rst_b = 1'b1; base = cyc;
    px("b_rel_x0",   1, 0,   3'b001, 24'hFFFFFF);
    px("b_rel_x1",   1, 1,   3'b001, 24'hFFFFFF);
    px("b_rel_l1",   1, 47,  3'b001, 24'hFFFFFF);
    px("b_rel_vpre", 1, 375, 3'b000, 24'h000000);
    px("b_rel_vs",   1, 376, 3'b010, 24'h000000);
    drain(1000);

    // Small raster, active-low sync
    push_at("c_reset", 2, cyc, 3'b110, 24'h000000);
    @(negedge clk);
    rst_c = 1'b1; base = cyc;
    px("c_x0",      2, 0,   3'b111, 24'hFFFFFF);
    px("c_x35",     2, 35,  3'b110, 24'h000000);
    px("c_hs_pre",  2, 37,  3'b110, 24'h000000);
    px("c_hs_fall", 2, 38,  3'b010, 24'h000000);
    px("c_hs_last", 2, 41,  3'b010, 24'h000000);
    px("c_hs_rise", 2, 42,  3'b110, 24'h000000);
    px("c_l1_x0",   2, 47,  3'b111, 24'hFFFFFF);
    px("c_vs_pre",  2, 375, 3'b110, 24'h000000);
    px("c_vs_fall", 2, 376, 3'b100, 24'h000000);
    px("c_vs_hs",   2, 414, 3'b000, 24'h000000);
    px("c_vs_last", 2, 516, 3'b100, 24'h000000);
    px("c_vs_rise", 2, 517, 3'b110, 24'h000000);
    drain(1000);

    while (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: expected check at cycle %0d never reached (now %0d)", e.name, e.cyc, cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
